// File: rtl/uart_rx_pkg.sv
// Shared definitions for the AHB-Lite UART receiver: register offsets,
// receive FSM encoding and oversampling constants.
package uart_rx_pkg;

  localparam logic [1:0] DATA_OFF   = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] CTRL_OFF   = 2'd2;
  localparam logic [1:0] PRESC_OFF  = 2'd3;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters. Pointers carry one extra wrap bit so
// full and empty are distinguished by the pointer difference.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push_s, do_pop_s;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LVL_W'(DEPTH));
  assign empty_o = (level_o == '0);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO only succeeds when a pop frees the head slot this cycle.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1 deserialiser with 16x oversampling, receive
// FIFO, sticky error flags and a level interrupt.
module ahbl_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        IRQ
);

  logic               ap_valid_q, ap_write_q;
  logic [1:0]         ap_addr_q;
  logic               en_q, ie_q, oe_q, fe_q, irq_q;
  logic [PRESC_W-1:0] presc_q, tick_cnt_q;
  logic               rx_meta_q, rx_s_q;
  rx_state_e          state_q;
  logic [3:0]         cnt4_q;
  logic [2:0]         bit_q;
  logic [7:0]         shreg_q;

  logic wr_s, rd_s, pop_s, ctrl_wr_s, presc_wr_s, status_wr_s;
  logic tick_s, stop_sample_s, push_s, oe_set_s, fe_set_s;
  logic [7:0] fifo_dout_s;
  logic fifo_full_s, fifo_empty_s;
  logic [$clog2(DEPTH):0] level_s;
  logic [31:0] hrdata_s;
  logic unused_s;

  assign unused_s    = ^{HSIZE, HADDR, HWDATA};
  assign HREADYOUT   = 1'b1;
  assign HRDATA      = hrdata_s;
  assign IRQ         = irq_q;

  assign wr_s        = ap_valid_q & ap_write_q;
  assign rd_s        = ap_valid_q & ~ap_write_q;
  assign pop_s       = rd_s & (ap_addr_q == DATA_OFF);
  assign ctrl_wr_s   = wr_s & (ap_addr_q == CTRL_OFF);
  assign presc_wr_s  = wr_s & (ap_addr_q == PRESC_OFF);
  assign status_wr_s = wr_s & (ap_addr_q == STATUS_OFF);

  assign tick_s        = en_q & (tick_cnt_q == presc_q);
  assign stop_sample_s = (state_q == ST_STOP) & tick_s & (cnt4_q == LAST_TICK);
  assign push_s        = stop_sample_s & rx_s_q;
  assign fe_set_s      = stop_sample_s & ~rx_s_q;
  assign oe_set_s      = push_s & fifo_full_s & ~pop_s;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (shreg_q),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_s)
  );

  // Read mux, driven only during a read data phase
  always_comb begin
    hrdata_s = 32'd0;
    if (rd_s) begin
      case (ap_addr_q)
        DATA_OFF:   hrdata_s[7:0] = fifo_empty_s ? 8'd0 : fifo_dout_s;
        STATUS_OFF: hrdata_s[15:0] = {8'(level_s), 4'd0, fe_q, oe_q, fifo_full_s, ~fifo_empty_s};
        CTRL_OFF:   hrdata_s[1:0] = {ie_q, en_q};
        PRESC_OFF:  hrdata_s[PRESC_W-1:0] = presc_q;
        default:    hrdata_s = 32'd0;
      endcase
    end else begin
      hrdata_s = 32'd0;
    end
  end

  // Address-phase capture, bus registers, sticky flags and interrupt
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q <= 1'b0;
      ap_write_q <= 1'b0;
      ap_addr_q  <= 2'd0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      presc_q    <= '0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ap_valid_q <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        ap_write_q <= HWRITE;
        ap_addr_q  <= HADDR[3:2];
      end
      if (ctrl_wr_s) begin
        en_q <= HWDATA[0];
        ie_q <= HWDATA[1];
      end
      if (presc_wr_s) presc_q <= HWDATA[PRESC_W-1:0];
      // A new error in the same cycle as its W1C clear keeps the flag set.
      oe_q  <= oe_set_s | (oe_q & ~(status_wr_s & HWDATA[2]));
      fe_q  <= fe_set_s | (fe_q & ~(status_wr_s & HWDATA[3]));
      irq_q <= ie_q & (~fifo_empty_s | oe_q | fe_q);
    end
  end

  // Input synchroniser and baud tick prescaler
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      if (!en_q || presc_wr_s || tick_s) tick_cnt_q <= '0;
      else                               tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Receive FSM: start validation at mid-bit, then one sample per 16 ticks
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt4_q  <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
    end else if (!en_q) begin
      state_q <= ST_IDLE;
      cnt4_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt4_q <= 4'd0;
          if (!rx_s_q) state_q <= ST_START;
        end
        ST_START: begin
          if (tick_s) begin
            if (cnt4_q == MID_TICK) begin
              state_q <= rx_s_q ? ST_IDLE : ST_DATA;
              cnt4_q  <= 4'd0;
              bit_q   <= 3'd0;
            end else begin
              cnt4_q <= cnt4_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            cnt4_q <= cnt4_q + 4'd1;
            if (cnt4_q == LAST_TICK) begin
              shreg_q <= {rx_s_q, shreg_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            cnt4_q <= cnt4_q + 4'd1;
            if (cnt4_q == LAST_TICK) state_q <= rx_s_q ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Randomised scoreboard bench for ahbl_uart_rx: a queue-based model of the
// receiver predicts every register read and IRQ sample.
module tb_ahbl_uart_rx;

  localparam int DEPTH = 16;
  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8, A_PRESC = 4'hC;

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, rx, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahbl_uart_rx dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .rx(rx), .IRQ(IRQ)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        mon_rd = 1'b0, mon_irq = 1'b0, end_chk = 1'b0, end_done = 1'b0;
  int          checks = 0, errors = 0;

  // Reference model state
  logic [7:0]  m_fifo[$];
  logic        m_oe = 1'b0, m_fe = 1'b0, m_en = 1'b0, m_ie = 1'b0;
  logic [15:0] m_presc = 16'd0;

  always @(negedge HCLK) begin
    logic [31:0] obs, e;
    string n;
    if (mon_rd || mon_irq) begin
      obs = mon_irq ? {31'd0, IRQ} : HRDATA;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %h with no expected value", obs);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, obs, e);
        end
      end
    end
    if (end_chk && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic hold(logic v, int n);
    rx = v;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_wr(logic [3:0] addr, logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
    HWDATA = 32'd0;
    if (addr == A_CTRL)  begin m_en = data[0]; m_ie = data[1]; end
    if (addr == A_PRESC) m_presc = data[15:0];
    if (addr == A_STATUS) begin
      if (data[2]) m_oe = 1'b0;
      if (data[3]) m_fe = 1'b0;
    end
  endtask

  task automatic bus_rd(logic [3:0] addr, logic [31:0] exp, string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    mon_rd = 1'b1;
    @(posedge HCLK); #1;
    mon_rd = 1'b0;
  endtask

  task automatic chk_irq(string name);
    logic e;
    e = m_ie & ((m_fifo.size() != 0) | m_oe | m_fe);
    exp_q.push_back({31'd0, e});
    name_q.push_back(name);
    @(posedge HCLK); #1;
    mon_irq = 1'b1;
    @(posedge HCLK); #1;
    mon_irq = 1'b0;
  endtask

  task automatic chk_data(string name);
    logic [31:0] e;
    e = (m_fifo.size() != 0) ? {24'd0, m_fifo.pop_front()} : 32'd0;
    bus_rd(A_DATA, e, name);
  endtask

  task automatic chk_status(string name);
    int lvl;
    lvl = m_fifo.size();
    bus_rd(A_STATUS, {16'd0, 8'(lvl), 4'd0, m_fe, m_oe, lvl == DEPTH, lvl != 0}, name);
  endtask

  // Drives one 8N1 frame and applies the receive rules to the model.
  task automatic send_frame(logic [7:0] b, logic stop, int bit_clks);
    hold(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) hold(b[i], bit_clks);
    hold(stop, bit_clks);
    hold(1'b1, 8);
    if (m_en) begin
      if (!stop)                     m_fe = 1'b1;
      else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
      else                           m_oe = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         p;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HSIZE = 3'b010;
    HWRITE = 1'b0; HREADY = 1'b1; HWDATA = 32'd0; rx = 1'b1;
    idle(4);
    HRESETn = 1'b1;
    idle(2);

    chk_status("reset_status");
    bus_rd(A_CTRL, 32'd0, "reset_ctrl");
    bus_rd(A_PRESC, 32'd0, "reset_presc");
    chk_data("reset_data");
    chk_irq("reset_irq");

    // Basic reception at PRESC=0
    bus_wr(A_PRESC, 32'd0);
    bus_wr(A_CTRL, 32'd1);
    send_frame(8'hA5, 1'b1, 16);
    chk_status("t1_status_one");
    chk_data("t1_data_a5");
    chk_status("t1_status_empty");
    chk_data("t1_data_empty");

    // Short glitch is rejected, then a real frame still works
    hold(1'b0, 4);
    hold(1'b1, 30);
    chk_status("t2_glitch_status");
    send_frame(8'hC3, 1'b1, 16);
    chk_data("t2_after_glitch");

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 16);
    chk_status("t3_full_status");
    for (int i = 0; i < 16; i++) chk_data("t3_drain");
    bus_wr(A_STATUS, 32'h4);
    chk_status("t3_oe_cleared");

    // Framing error, recovery and W1C
    send_frame(8'h3C, 1'b0, 16);
    chk_status("t4_fe_status");
    send_frame(8'h55, 1'b1, 16);
    chk_data("t4_data_55");
    bus_wr(A_STATUS, 32'h8);
    chk_status("t4_fe_cleared");

    // Interrupt behaviour
    bus_wr(A_CTRL, 32'h3);
    chk_irq("t5_irq_idle");
    send_frame(8'h01, 1'b1, 16);
    chk_irq("t5_irq_set");
    chk_data("t5_data_01");
    chk_irq("t5_irq_cleared");
    bus_wr(A_CTRL, 32'h1);
    send_frame(8'h22, 1'b1, 16);
    chk_irq("t5_irq_masked");
    chk_data("t5_data_22");

    // EN cleared mid-frame loses only the partial byte
    hold(1'b0, 16);
    hold(1'b1, 16); hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 16);
    bus_wr(A_CTRL, 32'h0);
    hold(1'b1, 8);
    bus_wr(A_CTRL, 32'h1);
    send_frame(8'h7E, 1'b1, 16);
    chk_status("t6_status_one");
    chk_data("t6_data_7e");
    chk_data("t6_data_empty");

    // PRESC=3 gives a 64-clock bit period
    bus_wr(A_PRESC, 32'd3);
    bus_rd(A_PRESC, 32'd3, "t6_presc_rb");
    send_frame(8'h96, 1'b1, 64);
    chk_data("t6_presc3_data");

    // Randomised frames, prescalers and interleaved reads
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(0, 2);
      bus_wr(A_PRESC, 32'(p));
      if ($urandom_range(0, 1) == 1) bus_wr(A_CTRL, 32'h3);
      else                           bus_wr(A_CTRL, 32'h1);
      b = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, 16 * (p + 1));
      chk_irq("rnd_irq");
      if ($urandom_range(0, 2) != 0) chk_data("rnd_data");
      chk_status("rnd_status");
      if (m_fe) bus_wr(A_STATUS, 32'h8);
    end
    while (m_fifo.size() != 0) chk_data("rnd_drain");
    chk_status("rnd_final_status");

    // Reset mid-frame with a byte buffered
    bus_wr(A_PRESC, 32'd0);
    bus_wr(A_CTRL, 32'h3);
    send_frame(8'h81, 1'b1, 16);
    hold(1'b0, 40);
    HRESETn = 1'b0;
    idle(3);
    rx = 1'b1;
    HRESETn = 1'b1;
    m_fifo.delete(); m_oe = 1'b0; m_fe = 1'b0; m_en = 1'b0; m_ie = 1'b0; m_presc = 16'd0;
    idle(2);
    chk_status("rst_mid_status");
    bus_rd(A_CTRL, 32'd0, "rst_mid_ctrl");
    chk_irq("rst_mid_irq");
    chk_data("rst_mid_data");

    end_chk = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
